// File: rtl/mc_wr_unpack.sv
// mc_wr_unpack: splits a 32-bit write word into 1, 2 or 4 right-aligned beats
// for an 8/16/32-bit memory bus, with registered beat outputs.
// Bus width encoding: 2'b00 = 8-bit, 2'b01 = 16-bit, 2'b10 = 32-bit, 2'b11 = one full beat.
// Optional feature: define MC_WR_PARITY_EN to generate per-byte even parity on mem_dp_o.
module mc_wr_unpack (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  bus_width,
   input  logic        clr,
   input  logic        wr_valid,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_be,
   output logic        wr_ready,
   output logic        mem_valid,
   input  logic        mem_ack,
   output logic [31:0] mem_data_o,
   output logic [3:0]  mem_be_o,
   output logic [3:0]  mem_dp_o,
   output logic        mem_last
);

   localparam logic [1:0] MC_BW_8  = 2'b00;
   localparam logic [1:0] MC_BW_16 = 2'b01;

   typedef enum logic {IDLE, SEND} state_t;

   state_t      state_q, state_d;
   logic [31:0] data_q, data_d;
   logic [3:0]  be_q, be_d;
   logic [1:0]  bw_q, bw_d;
   logic [1:0]  idx_q, idx_d;
   logic        valid_d, last_d;
   logic [31:0] odata_d;
   logic [3:0]  obe_d;

   logic        load, advance, present;
   logic [31:0] src_data;
   logic [3:0]  src_be;
   logic [1:0]  src_bw, src_idx, src_last_idx;
   logic [31:0] beat_data;
   logic [3:0]  beat_be;
   logic        beat_last;

   // Handshake: accept a word when idle, or when the final beat is being acked
   always_comb begin
      wr_ready = !clr && ((state_q == IDLE) || ((state_q == SEND) && mem_last && mem_ack));
      load     = wr_valid && wr_ready;
      advance  = (state_q == SEND) && mem_valid && mem_ack;
   end

   // Beat slicer: a fresh load presents beat 0 of the incoming word, otherwise the next latched beat
   always_comb begin
      src_data = load ? wr_data   : data_q;
      src_be   = load ? wr_be     : be_q;
      src_bw   = load ? bus_width : bw_q;
      src_idx  = load ? 2'd0      : idx_q + 2'd1;
      beat_data = src_data;
      beat_be   = src_be;
      src_last_idx = 2'd0;
      case (src_bw)
         MC_BW_8: begin
            beat_data    = {24'h0, src_data[8*src_idx +: 8]};
            beat_be      = {3'b0, src_be[src_idx]};
            src_last_idx = 2'd3;
         end
         MC_BW_16: begin
            beat_data    = {16'h0, src_data[16*src_idx[0] +: 16]};
            beat_be      = {2'b0, src_be[2*src_idx[0] +: 2]};
            src_last_idx = 2'd1;
         end
         default: begin
            beat_data    = src_data;
            beat_be      = src_be;
            src_last_idx = 2'd0;
         end
      endcase
      beat_last = (src_idx == src_last_idx);
   end

   // Next-state logic: clr beats load, load beats ack, and ack without a pending beat is ignored
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      be_d    = be_q;
      bw_d    = bw_q;
      idx_d   = idx_q;
      valid_d = mem_valid;
      last_d  = mem_last;
      odata_d = mem_data_o;
      obe_d   = mem_be_o;
      present = 1'b0;
      if (clr) begin
         state_d = IDLE;
         idx_d   = 2'd0;
         valid_d = 1'b0;
         last_d  = 1'b0;
         odata_d = 32'h0;
         obe_d   = 4'h0;
      end else if (load) begin
         state_d = SEND;
         data_d  = wr_data;
         be_d    = wr_be;
         bw_d    = bus_width;
         idx_d   = 2'd0;
         present = 1'b1;
      end else if (advance) begin
         if (mem_last) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end else begin
            idx_d   = idx_q + 2'd1;
            present = 1'b1;
         end
      end
      if (present) begin
         valid_d = 1'b1;
         last_d  = beat_last;
         odata_d = beat_data;
         obe_d   = beat_be;
      end
   end

   // State, latched word and registered beat outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         data_q     <= 32'h0;
         be_q       <= 4'h0;
         bw_q       <= 2'b00;
         idx_q      <= 2'd0;
         mem_valid  <= 1'b0;
         mem_last   <= 1'b0;
         mem_data_o <= 32'h0;
         mem_be_o   <= 4'h0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         be_q       <= be_d;
         bw_q       <= bw_d;
         idx_q      <= idx_d;
         mem_valid  <= valid_d;
         mem_last   <= last_d;
         mem_data_o <= odata_d;
         mem_be_o   <= obe_d;
      end
   end

`ifdef MC_WR_PARITY_EN
   // Even parity per byte, registered alongside the beat it belongs to
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_dp_o <= 4'h0;
      end else if (clr) begin
         mem_dp_o <= 4'h0;
      end else if (present) begin
         mem_dp_o <= {^beat_data[31:24], ^beat_data[23:16], ^beat_data[15:8], ^beat_data[7:0]};
      end
   end
`else
   assign mem_dp_o = 4'b0000;
`endif

endmodule

// File: tb/tb_mc_wr_unpack.sv
// Testbench for mc_wr_unpack: directed scenarios plus random traffic checked
// against a queue-of-beats reference model.
module tb_mc_wr_unpack;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  bus_width;
   logic        clr;
   logic        wr_valid;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        wr_ready;
   logic        mem_valid;
   logic        mem_ack;
   logic [31:0] mem_data_o;
   logic [3:0]  mem_be_o;
   logic [3:0]  mem_dp_o;
   logic        mem_last;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  be;
      logic        last;
   } beat_t;

   beat_t modelQ[$];
   int    checks = 0;
   int    errors = 0;
   logic  clearedLast = 1'b0;

   mc_wr_unpack dut (
      .clk(clk), .rst(rst), .bus_width(bus_width), .clr(clr),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_be(wr_be), .wr_ready(wr_ready),
      .mem_valid(mem_valid), .mem_ack(mem_ack), .mem_data_o(mem_data_o),
      .mem_be_o(mem_be_o), .mem_dp_o(mem_dp_o), .mem_last(mem_last)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] expParity(input logic [31:0] d);
`ifdef MC_WR_PARITY_EN
      expParity = {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
`else
      expParity = 4'b0000;
`endif
   endfunction

   // Model: a word becomes a list of beats; the memory side consumes them one per ack
   task automatic makeBeats(input logic [31:0] w, input logic [3:0] b, input logic [1:0] bw);
      int n;
      beat_t bt;
      modelQ.delete();
      n = (bw == 2'b00) ? 4 : (bw == 2'b01) ? 2 : 1;
      for (int k = 0; k < n; k++) begin
         if (n == 4) begin
            bt.d  = {24'h0, w[8*k +: 8]};
            bt.be = {3'b0, b[k]};
         end else if (n == 2) begin
            bt.d  = {16'h0, w[16*k +: 16]};
            bt.be = {2'b0, b[2*k +: 2]};
         end else begin
            bt.d  = w;
            bt.be = b;
         end
         bt.last = (k == n - 1);
         modelQ.push_back(bt);
      end
   endtask

   // One clock cycle: drive inputs, check wr_ready, advance the model, check the registered beat
   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [3:0] b,
                                input logic [1:0] bw, input logic ack, input logic c);
      logic expReady;
      @(negedge clk);
      wr_valid  = v;
      wr_data   = d;
      wr_be     = b;
      bus_width = bw;
      mem_ack   = ack;
      clr       = c;
      #1;
      expReady = !c && (modelQ.size() == 0 || (modelQ.size() == 1 && ack));
      checkOutput("wr_ready", {31'h0, wr_ready}, {31'h0, expReady});
      clearedLast = c;
      if (c) begin
         modelQ.delete();
      end else begin
         if (ack && modelQ.size() > 0) void'(modelQ.pop_front());
         if (v && expReady) makeBeats(d, b, bw);
      end
      @(posedge clk);
      #1;
      checkOutput("mem_valid", {31'h0, mem_valid}, {31'h0, modelQ.size() > 0});
      if (modelQ.size() > 0) begin
         checkOutput("mem_data_o", mem_data_o, modelQ[0].d);
         checkOutput("mem_be_o", {28'h0, mem_be_o}, {28'h0, modelQ[0].be});
         checkOutput("mem_last", {31'h0, mem_last}, {31'h0, modelQ[0].last});
         checkOutput("mem_dp_o", {28'h0, mem_dp_o}, {28'h0, expParity(modelQ[0].d)});
      end else if (clearedLast) begin
         checkOutput("mem_be_o_clr", {28'h0, mem_be_o}, 32'h0);
      end
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0; wr_valid = 1'b0; wr_data = 32'h0; wr_be = 4'h0;
      bus_width = 2'b00; mem_ack = 1'b0;
      #3;
      checkOutput("reset_valid", {31'h0, mem_valid}, 32'h0);
      checkOutput("reset_data", mem_data_o, 32'h0);
      checkOutput("reset_be", {28'h0, mem_be_o}, 32'h0);
      #9 rst = 1'b1;

      // 32-bit bus, ack tied high: single beat then idle
      applyStimulus(1, 32'hA1B2C3D4, 4'hF, 2'b10, 1, 0);
      applyStimulus(0, 32'h0, 4'h0, 2'b10, 1, 0);
      applyStimulus(0, 32'h0, 4'h0, 2'b10, 1, 0);

      // 8-bit bus, ack every cycle: four byte beats
      applyStimulus(1, 32'h11223344, 4'b1010, 2'b00, 1, 0);
      repeat (4) applyStimulus(0, 32'h0, 4'h0, 2'b00, 1, 0);

      // 16-bit bus with stalled beat 0, bus_width changing mid-word
      applyStimulus(1, 32'hDEADBEEF, 4'hF, 2'b01, 0, 0);
      repeat (3) applyStimulus(0, 32'h0, 4'h0, 2'b10, 0, 0);
      applyStimulus(0, 32'h0, 4'h0, 2'b00, 1, 0);
      applyStimulus(0, 32'h0, 4'h0, 2'b01, 1, 0);

      // Back-to-back 16-bit words with wr_valid held
      applyStimulus(1, 32'h12345678, 4'h3, 2'b01, 1, 0);
      applyStimulus(1, 32'h9ABCDEF0, 4'hC, 2'b01, 1, 0);
      applyStimulus(1, 32'h9ABCDEF0, 4'hC, 2'b01, 1, 0);
      applyStimulus(0, 32'h0, 4'h0, 2'b01, 1, 0);
      applyStimulus(0, 32'h0, 4'h0, 2'b01, 1, 0);

      // Abort during beat 2 of an 8-bit word, clr competing with a load
      applyStimulus(1, 32'hCAFEF00D, 4'hF, 2'b00, 1, 0);
      applyStimulus(0, 32'h0, 4'h0, 2'b00, 1, 0);
      applyStimulus(1, 32'h55555555, 4'hF, 2'b00, 1, 1);
      applyStimulus(0, 32'h0, 4'h0, 2'b00, 1, 0);

      // Asynchronous reset in the middle of a word
      applyStimulus(1, 32'h87654321, 4'hF, 2'b00, 0, 0);
      @(negedge clk);
      wr_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      checkOutput("async_valid", {31'h0, mem_valid}, 32'h0);
      checkOutput("async_data", mem_data_o, 32'h0);
      checkOutput("async_be", {28'h0, mem_be_o}, 32'h0);
      checkOutput("async_last", {31'h0, mem_last}, 32'h0);
      checkOutput("async_dp", {28'h0, mem_dp_o}, 32'h0);
      modelQ.delete();
      #1 rst = 1'b1;
      applyStimulus(0, 32'h0, 4'h0, 2'b00, 0, 0);

      // Parity vector on a 32-bit bus
      applyStimulus(1, 32'h01030700, 4'hF, 2'b10, 0, 0);
      checkOutput("parity_vec", {28'h0, mem_dp_o}, {28'h0, expParity(32'h01030700)});
      applyStimulus(0, 32'h0, 4'h0, 2'b10, 1, 0);

      // Random traffic, including ack while idle and the unused bus encoding
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 1) == 1, $urandom, 4'($urandom_range(0, 15)),
                       2'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
                       $urandom_range(0, 19) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
